hd_pair_deser: RTL and testbench
================================

Name: hd_pair_deser

Overview:
Serial-to-parallel front end that sits directly upstream of the Hamming(7,4) pair decoder. It collects a 14-bit serial frame and presents it as two 7-bit code words (code_word1, code_word2) with a valid/ready handshake. Partial frames that stall too long are dropped, and each drop raises a one-cycle error pulse.

Parameters:
GAP_MAX, 8, consecutive idle (in_valid low) cycles allowed mid-frame before abort; 0 disables the timeout
GAP_W, 4, width of the gap counter; must hold GAP_MAX

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  serial data bit
in_ready  output  1  block can accept a bit this cycle
code_word1  output  7  first code word of the frame
code_word2  output  7  second code word of the frame
out_valid  output  1  code words valid, held until accepted
out_ready  input  1  downstream accepts the code words
frame_err  output  1  one-cycle pulse: partial frame aborted by timeout

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values: in_ready=0 during reset, then 1 in IDLE. code_word1=0, code_word2=0, out_valid=0, frame_err=0. Bit counter=0, gap counter=0, state=IDLE. Reset mid-frame or mid-HOLD discards everything.
- Bit acceptance: a bit is accepted when in_valid && in_ready. in_ready = (state != HOLD).
- Bit order, first to last: code_word1[6] .. code_word1[0], then code_word2[6] .. code_word2[0].
- State IDLE:
  - accepted bit -> store bit 0, cnt=1, state SHIFT.
  - otherwise remain in IDLE; the gap counter does not run.
- State SHIFT:
  - accepted bit -> store it, cnt++, gap=0.
  - On acceptance of the 14th bit (cnt==13): the next cycle has code_word1/2 loaded, out_valid=1, cnt=0, state HOLD.
  - No bit this cycle -> gap++. If GAP_MAX!=0 and gap reaches GAP_MAX: the next cycle has frame_err=1 for one cycle, cnt=0, gap=0, state IDLE, partial bits discarded.
  - code_word1/2 are unchanged on abort.
- State HOLD:
  - out_valid=1; code_word1/2 stable; in_ready=0.
  - On out_valid && out_ready: the next cycle has out_valid=0 and state IDLE.
  - If out_ready is already high on entry, the handshake completes in the first HOLD cycle.
- Timing: latency from the 14th accepted bit to out_valid is 1 cycle. Minimum frame period is 15 cycles (14 bits + 1 handshake cycle).
- code_word1/2 update only on frame completion and keep their last value after the handshake.
- Simultaneous events:
  - rst has priority over everything.
  - On the cycle the gap counter reaches GAP_MAX, a bit accepted that same cycle counts; no abort, gap clears.
  - in_valid during HOLD is ignored (not accepted).

Optional Feature:
HD_SYNDROME_EN
- Defined: adds outputs syn1[2:0] and syn2[2:0], registered and loaded with code_word1/2.
  - Syndrome of word w: {w6^w3^w2^w1, w5^w3^w2^w0, w4^w3^w1^w0}.
  - Reset value 0; valid while out_valid.
- Undefined: ports and logic are absent.

Decomposition:
- Package hd_pkg holds:
  - CW_W=7, FRAME_BITS=14.
  - State enum {IDLE, SHIFT, HOLD}.
  - Parity/syndrome function, shared with the decoder.
- Sub-module hd_syndrome (combinational, 7-bit in, 3-bit out) is instantiated twice, only under HD_SYNDROME_EN. The main FSM stays in hd_pair_deser.

Test Plan:
- Basic frame: send 0011011 then 1010010 back-to-back, out_ready=1 -> out_valid on the cycle after bit 14, code_word1=7'h1B, code_word2=7'h52, one cycle wide, in_ready high next cycle.
- Backpressure: same frame with out_ready=0 for 5 cycles -> out_valid and code words held 5 cycles, in_ready=0 throughout, in_valid pulses ignored; release out_ready -> IDLE next cycle.
- Timeout: 6 bits, then in_valid=0 for 8 cycles (GAP_MAX=8) -> frame_err pulses once. The next 14 bits form a clean frame; old code words are held until then.
- Gap below limit: 7-cycle gap mid-frame -> no frame_err, frame completes correctly.
- Reset mid-frame: assert rst after bit 10 -> out_valid=0, code words 0; a following 14-bit frame decodes correctly.
- HD_SYNDROME_EN: code_word1=7'h1B -> syn1=3'b000; code_word1=7'h13 (bit 3 flipped) -> syn1=3'b111.

Source files
------------

// File: rtl/hd_pkg.sv
// Shared definitions for the Hamming(7,4) pair deserializer and decoder:
// frame geometry, FSM state encoding and the syndrome calculation.
package hd_pkg;

   localparam int CW_W       = 7;
   localparam int FRAME_BITS = 2 * CW_W;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } state_t;

   // Bits are {s2, s1, s0}. An all-zero result means the word has no detected error.
   function automatic logic [2:0] hd_calc_syndrome(input logic [CW_W-1:0] w);
      return {w[6] ^ w[3] ^ w[2] ^ w[1],
              w[5] ^ w[3] ^ w[2] ^ w[0],
              w[4] ^ w[3] ^ w[1] ^ w[0]};
   endfunction

endpackage

// File: rtl/hd_syndrome.sv
// Combinational syndrome of one 7-bit Hamming code word.
module hd_syndrome
   import hd_pkg::*;
(
   input  logic [CW_W-1:0] word,
   output logic [2:0]      syn
);

   assign syn = hd_calc_syndrome(word);

endmodule

// File: rtl/hd_pair_deser.sv
// Collects 14 serial bits into two 7-bit code words, offered downstream with
// valid/ready. Stalled partial frames are dropped. HD_SYNDROME_EN adds the syn1/syn2 outputs.
module hd_pair_deser
   import hd_pkg::*;
#(
   parameter int GAP_MAX = 8,
   parameter int GAP_W   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            in_bit,
   output logic            in_ready,
   output logic [CW_W-1:0] code_word1,
   output logic [CW_W-1:0] code_word2,
   output logic            out_valid,
   input  logic            out_ready,
`ifdef HD_SYNDROME_EN
   output logic [2:0]      syn1,
   output logic [2:0]      syn2,
`endif
   output logic            frame_err
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_MAX);

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic [GAP_W-1:0]        gap;
   logic [GAP_W-1:0]        gap_inc;
   logic [FRAME_BITS-2:0]   shreg;
   logic [FRAME_BITS-1:0]   frame_nxt;
   logic                    accept;
   logic                    done;
   logic                    abort;

   assign in_ready  = !rst && (state != HOLD);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;
   assign gap_inc   = gap + 1'b1;
   // The first bit received lands in frame_nxt[13], i.e. code_word1[6].
   assign frame_nxt = {shreg, in_bit};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      abort     = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (accept) begin
               if (cnt == LAST_BIT) begin
                  done      = 1'b1;
                  state_nxt = HOLD;
               end
            end else if ((GAP_MAX != 0) && (gap_inc == GAP_LIM)) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         gap        <= '0;
         shreg      <= '0;
         code_word1 <= '0;
         code_word2 <= '0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= abort;
         if (accept) begin
            shreg <= frame_nxt[FRAME_BITS-2:0];
            gap   <= '0;
            cnt   <= done ? '0 : cnt + 1'b1;
         end else if (abort) begin
            cnt <= '0;
            gap <= '0;
         end else if (state == SHIFT) begin
            gap <= gap_inc;
         end
         if (done) begin
            code_word1 <= frame_nxt[FRAME_BITS-1:CW_W];
            code_word2 <= frame_nxt[CW_W-1:0];
         end
      end
   end

`ifdef HD_SYNDROME_EN
   logic [2:0] syn1_nxt;
   logic [2:0] syn2_nxt;

   hd_syndrome u_syn1 (
      .word (frame_nxt[FRAME_BITS-1:CW_W]),
      .syn  (syn1_nxt)
   );

   hd_syndrome u_syn2 (
      .word (frame_nxt[CW_W-1:0]),
      .syn  (syn2_nxt)
   );

   // Loaded alongside the code words so the syndromes always describe the held frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         syn1 <= '0;
         syn2 <= '0;
      end else if (done) begin
         syn1 <= syn1_nxt;
         syn2 <= syn2_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_hd_pair_deser.sv
// Self-checking bench for hd_pair_deser; the HD_SYNDROME_EN build adds syndrome checks.
module tb_hd_pair_deser;

   localparam int GAP_MAX = 8;
   localparam int GAP_W   = 4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic [6:0] code_word1;
   logic [6:0] code_word2;
   logic       out_valid;
   logic       out_ready;
   logic       frame_err;
`ifdef HD_SYNDROME_EN
   logic [2:0] syn1;
   logic [2:0] syn2;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   hd_pair_deser #(.GAP_MAX(GAP_MAX), .GAP_W(GAP_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .in_ready   (in_ready),
      .code_word1 (code_word1),
      .code_word2 (code_word2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef HD_SYNDROME_EN
      .syn1       (syn1),
      .syn2       (syn2),
`endif
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Send bits f[13-first] .. f[13-first-count+1], one per cycle, then drop in_valid.
   task automatic send_range(input logic [13:0] f, input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         in_valid = 1'b1;
         in_bit   = f[13-i];
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   function automatic logic [2:0] ref_syn(input logic [6:0] w);
      return {w[6] ^ w[3] ^ w[2] ^ w[1], w[5] ^ w[3] ^ w[2] ^ w[0], w[4] ^ w[3] ^ w[1] ^ w[0]};
   endfunction

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_tests++;
      if (out_valid !== 1'b0 || frame_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: got out_valid=%b frame_err=%b expected 0 0", out_valid, frame_err);
      end
      n_tests++;
      if (code_word1 !== 7'h00 || code_word2 !== 7'h00) begin
         n_fail++; $display("FAIL reset_words: got %h %h expected 00 00", code_word1, code_word2);
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_basic;
      logic [13:0] f;
      f = {7'b0011011, 7'b1010010};
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         n_tests++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_shift_bit%0d: got out_valid=%b in_ready=%b expected 0 1", i, out_valid, in_ready);
         end
         in_valid = 1'b1; in_bit = f[13-i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL basic_latency: got out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
      end
      n_tests++;
      if (code_word1 !== 7'h1B || code_word2 !== 7'h52) begin
         n_fail++; $display("FAIL basic_words: got %h %h expected 1b 52", code_word1, code_word2);
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL basic_one_cycle: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
      n_tests++;
      if (code_word1 !== 7'h1B || code_word2 !== 7'h52) begin
         n_fail++; $display("FAIL basic_words_kept: got %h %h expected 1b 52", code_word1, code_word2);
      end
   endtask

   task automatic test_backpressure;
      logic [13:0] f;
      f = 14'($urandom);
      out_ready = 1'b0;
      send_range(f, 0, 14);
      for (int k = 0; k < 6; k++) begin
         n_tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || code_word1 !== f[13:7] || code_word2 !== f[6:0]) begin
            n_fail++;
            $display("FAIL bp_hold_cycle%0d: got valid=%b ready=%b words=%h %h expected 1 0 %h %h",
                     k, out_valid, in_ready, code_word1, code_word2, f[13:7], f[6:0]);
         end
         in_valid = 1'($urandom_range(0, 1));
         in_bit   = 1'($urandom_range(0, 1));
         if (k < 5) @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_timeout;
      logic [6:0]  old1, old2;
      logic [13:0] f;
      old1 = code_word1; old2 = code_word2;
      f = 14'($urandom);
      send_range(14'($urandom), 0, 6);
      for (int j = 0; j < GAP_MAX; j++) begin
         @(negedge clk);
         n_tests++;
         if (frame_err !== (j == GAP_MAX - 1)) begin
            n_fail++; $display("FAIL timeout_err_gap%0d: got %b expected %b", j, frame_err, (j == GAP_MAX - 1));
         end
      end
      @(negedge clk);
      n_tests++;
      if (frame_err !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL timeout_pulse_end: got err=%b ready=%b valid=%b expected 0 1 0", frame_err, in_ready, out_valid);
      end
      n_tests++;
      if (code_word1 !== old1 || code_word2 !== old2) begin
         n_fail++; $display("FAIL timeout_words_held: got %h %h expected %h %h", code_word1, code_word2, old1, old2);
      end
      send_range(f, 0, 14);
      n_tests++;
      if (out_valid !== 1'b1 || code_word1 !== f[13:7] || code_word2 !== f[6:0]) begin
         n_fail++; $display("FAIL timeout_next_frame: got valid=%b %h %h expected 1 %h %h",
                            out_valid, code_word1, code_word2, f[13:7], f[6:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_gap_below;
      logic [13:0] f;
      f = 14'($urandom);
      send_range(f, 0, 5);
      for (int j = 0; j < GAP_MAX - 1; j++) begin
         @(negedge clk);
         n_tests++;
         if (frame_err !== 1'b0) begin n_fail++; $display("FAIL gap_below_err%0d: got %b expected 0", j, frame_err); end
      end
      send_range(f, 5, 9);
      n_tests++;
      if (out_valid !== 1'b1 || frame_err !== 1'b0 || code_word1 !== f[13:7] || code_word2 !== f[6:0]) begin
         n_fail++; $display("FAIL gap_below_frame: got valid=%b err=%b %h %h expected 1 0 %h %h",
                            out_valid, frame_err, code_word1, code_word2, f[13:7], f[6:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_frame;
      logic [13:0] f;
      f = 14'($urandom);
      send_range(14'($urandom), 0, 10);
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || code_word1 !== 7'h00 || code_word2 !== 7'h00) begin
         n_fail++; $display("FAIL rst_mid_state: got valid=%b ready=%b %h %h expected 0 0 00 00",
                            out_valid, in_ready, code_word1, code_word2);
      end
      rst = 1'b0;
      @(negedge clk);
      send_range(f, 0, 14);
      n_tests++;
      if (out_valid !== 1'b1 || code_word1 !== f[13:7] || code_word2 !== f[6:0]) begin
         n_fail++; $display("FAIL rst_mid_next_frame: got valid=%b %h %h expected 1 %h %h",
                            out_valid, code_word1, code_word2, f[13:7], f[6:0]);
      end
      @(negedge clk);
   endtask

   // Stream-level model: bits collect in a queue; an over-long gap empties it and owes one frame_err.
   task automatic test_random;
      bit          q[$];
      int          exp_err = 0;
      int          seen_err = 0;
      int          g, w;
      logic        b;
      logic [13:0] f;
      out_ready = 1'b1;
      for (int n = 0; n < 400; n++) begin
         b = 1'($urandom_range(0, 1));
         if (q.size() == 0)                g = $urandom_range(0, 3);
         else if ($urandom_range(0, 7) == 0) g = GAP_MAX + $urandom_range(0, 3);
         else                              g = $urandom_range(0, GAP_MAX - 1);
         for (int k = 0; k < g; k++) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (frame_err === 1'b1) seen_err++;
         end
         if (q.size() > 0 && g >= GAP_MAX) begin
            exp_err++;
            q.delete();
         end
         in_valid = 1'b1; in_bit = b;
         @(negedge clk);
         if (frame_err === 1'b1) seen_err++;
         in_valid = 1'b0;
         q.push_back(b);
         if (q.size() == 14) begin
            for (int j = 0; j < 14; j++) f[13-j] = q[j];
            n_tests++;
            if (out_valid !== 1'b1 || code_word1 !== f[13:7] || code_word2 !== f[6:0]) begin
               n_fail++; $display("FAIL rand_frame_bit%0d: got valid=%b %h %h expected 1 %h %h",
                                  n, out_valid, code_word1, code_word2, f[13:7], f[6:0]);
            end
`ifdef HD_SYNDROME_EN
            n_tests++;
            if (syn1 !== ref_syn(f[13:7]) || syn2 !== ref_syn(f[6:0])) begin
               n_fail++; $display("FAIL rand_syn_bit%0d: got %b %b expected %b %b",
                                  n, syn1, syn2, ref_syn(f[13:7]), ref_syn(f[6:0]));
            end
`endif
            w = $urandom_range(0, 3);
            if (w > 0) begin
               out_ready = 1'b0;
               for (int k = 0; k < w; k++) begin
                  @(negedge clk);
                  n_tests++;
                  if (out_valid !== 1'b1 || code_word1 !== f[13:7]) begin
                     n_fail++; $display("FAIL rand_hold_bit%0d: got valid=%b %h expected 1 %h", n, out_valid, code_word1, f[13:7]);
                  end
               end
               out_ready = 1'b1;
            end
            @(negedge clk);
            if (frame_err === 1'b1) seen_err++;
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_release_bit%0d: got %b expected 0", n, out_valid); end
            q.delete();
         end
      end
      n_tests++;
      if (seen_err != exp_err) begin
         n_fail++; $display("FAIL rand_frame_err_count: got %0d expected %0d", seen_err, exp_err);
      end
   endtask

`ifdef HD_SYNDROME_EN
   task automatic test_syndrome;
      out_ready = 1'b1;
      send_range({7'h1B, 7'h52}, 0, 14);
      n_tests++;
      if (syn1 !== 3'b000 || syn2 !== 3'b000) begin
         n_fail++; $display("FAIL syn_clean: got %b %b expected 000 000", syn1, syn2);
      end
      @(negedge clk);
      send_range({7'h13, 7'h52}, 0, 14);
      n_tests++;
      if (syn1 !== 3'b111 || syn2 !== 3'b000) begin
         n_fail++; $display("FAIL syn_bit3_flip: got %b %b expected 111 000", syn1, syn2);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_gap_below();
      test_reset_mid_frame();
`ifdef HD_SYNDROME_EN
      test_syndrome();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
